// File: rtl/uop_issue.sv
// Micro-op issue sequencer: replays a uop-cache address range loop_count+1 times into a 2-entry output FIFO.
// Optional build macro UOP_ISSUE_STALL_CNT_EN adds a saturating stall_count output.
module uop_issue #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [7:0]        loop_count,
    input  logic              abort,
    output logic              cache_read_enable,
    output logic [ADDR_W-1:0] cache_read_address,
    input  logic [DATA_W-1:0] cache_instruction,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [DATA_W-1:0] uop_data,
    output logic              uop_last,
    output logic              busy,
`ifdef UOP_ISSUE_STALL_CNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] start_q, end_q, addr;
    logic [7:0]        loops_q, pass;
    logic              vld_p1, last_p1;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic [2:0]        occ;
    logic              accept, pop, push, room, last_addr, final_pass, issue_last, drained;

    assign accept     = (state == IDLE) && start && !abort;
    assign pop        = uop_valid && uop_ready;
    assign push       = vld_p1 && !abort;
    // Occupancy the FIFO will have once the pending read lands; a new read needs a free slot beyond it.
    assign occ        = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
    assign room       = occ < 3'd2;
    assign last_addr  = addr == end_q;
    assign final_pass = pass == loops_q;
    assign issue_last = cache_read_enable && last_addr && final_pass;
    assign drained    = !vld_p1 && (count == 2'd0);

    assign uop_valid          = count != 2'd0;
    assign uop_data           = uop_valid ? fifo_data[rd_ptr] : '0;
    assign uop_last           = uop_valid && fifo_last[rd_ptr];
    assign cache_read_address = addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (issue_last) state_nxt = DRAIN;
                DRAIN:   if (drained) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cache_read_enable = (state == RUN) && !abort && room;
        busy              = state != IDLE;
        done              = (state == DRAIN) && !abort && drained;
    end

    // Stage p0: sequence address / pass tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= '0;
            end_q   <= '0;
            loops_q <= '0;
            addr    <= '0;
            pass    <= '0;
        end else if (accept) begin
            start_q <= start_addr;
            end_q   <= end_addr;
            loops_q <= loop_count;
            addr    <= start_addr;
            pass    <= '0;
        end else if (cache_read_enable) begin
            if (!last_addr) begin
                addr <= addr + 1'b1;
            end else if (!final_pass) begin
                addr <= start_q;
                pass <= pass + 8'd1;
            end
        end
    end

    // Stage p1: read in flight, data returns from the cache this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (abort) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= cache_read_enable;
            last_p1 <= issue_last;
        end
    end

    // Stage p2: output FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= cache_instruction;
            fifo_last[wr_ptr] <= last_p1;
        end
    end

`ifdef UOP_ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (accept)
            stall_count <= '0;
        else if (uop_valid && !uop_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_uop_issue.sv
// Self-checking bench for uop_issue: queue-based reference of the issued address sequence with
// directed and randomized ready/start patterns, abort and asynchronous reset scenarios.
module tb_uop_issue;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              uop_ready = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [7:0]        loop_count = '0;
    logic              cache_read_enable;
    logic [ADDR_W-1:0] cache_read_address;
    logic [DATA_W-1:0] cache_instruction = '0;
    logic              uop_valid, uop_last, busy, done;
    logic [DATA_W-1:0] uop_data;
`ifdef UOP_ISSUE_STALL_CNT_EN
    logic [15:0]       stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    uop_issue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .start_addr         (start_addr),
        .end_addr           (end_addr),
        .loop_count         (loop_count),
        .abort              (abort),
        .cache_read_enable  (cache_read_enable),
        .cache_read_address (cache_read_address),
        .cache_instruction  (cache_instruction),
        .uop_valid          (uop_valid),
        .uop_ready          (uop_ready),
        .uop_data           (uop_data),
        .uop_last           (uop_last),
        .busy               (busy),
`ifdef UOP_ISSUE_STALL_CNT_EN
        .stall_count        (stall_count),
`endif
        .done               (done)
    );

    always #5 clk = ~clk;

    // Uop cache: entry n holds A000_0000+n, data appears the cycle after the read strobe.
    always @(posedge clk)
        cache_instruction <= cache_read_enable ? (32'hA000_0000 + 32'(cache_read_address)) : 32'hDEAD_BEEF;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if ({cache_read_enable, uop_valid, uop_last, busy, done} !== 5'b0 ||
            cache_read_address !== '0 || uop_data !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: got re=%b addr=%0d v=%b last=%b busy=%b done=%b data=%h want all 0",
                     name, cache_read_enable, cache_read_address, uop_valid, uop_last, busy, done, uop_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        start_addr = 6'd3;
        end_addr = 6'd9;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || cache_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b re=%b want 0 0", busy, cache_read_enable);
        end
`ifdef UOP_ISSUE_STALL_CNT_EN
        n_tests++;
        if (stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_count: got %0d want 0", stall_count);
        end
`endif
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: random ready.
    task automatic run_seq(input logic [5:0] s, input logic [5:0] e, input int lc, input int mode,
                           input bit noise, input string name);
        logic [31:0] exp_d[$];
        logic        exp_l[$];
        logic [5:0]  exp_a[$];
        logic [31:0] prev_data = '0;
        bit          prev_stall = 1'b0;
        bit          finished = 1'b0;
        int a, n, k, budget, got, reads, done_cnt, done_k, first_v, first_hs, last_hs, stalls;

        for (int p = 0; p <= lc; p++) begin
            a = int'(s);
            while (1) begin
                exp_a.push_back(6'(a));
                exp_d.push_back(32'hA000_0000 + 32'(a));
                exp_l.push_back(p == lc && a == int'(e));
                if (a == int'(e)) break;
                a = (a + 1) % 64;
            end
        end
        n = exp_d.size();
        budget = 8 * n + 30;
        got = 0; reads = 0; done_cnt = 0; done_k = -1; first_v = -1; first_hs = -1; last_hs = -1; stalls = 0;

        @(negedge clk);
        start = 1'b1; start_addr = s; end_addr = e; loop_count = 8'(lc); abort = 1'b0; uop_ready = 1'b1;
        k = 0;
        while (!finished && k < budget) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (noise && got < n - 1 && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                start_addr = 6'($urandom);
                end_addr = 6'($urandom);
                loop_count = 8'($urandom);
            end
            case (mode)
                0:       uop_ready = 1'b1;
                1:       uop_ready = (k % 4 == 1) || (k % 4 == 0);
                default: uop_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (done_k >= 0 && k == done_k + 1) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, busy, done);
                end
                finished = 1'b1;
            end
            if (cache_read_enable === 1'b1) begin
                n_tests++;
                if (reads >= n) begin
                    n_fail++;
                    $display("FAIL %s extra_read: got read #%0d at addr %0d want only %0d reads",
                             name, reads + 1, cache_read_address, n);
                end else if (cache_read_address !== exp_a[reads]) begin
                    n_fail++;
                    $display("FAIL %s read_addr[%0d]: got %0d want %0d", name, reads, cache_read_address, exp_a[reads]);
                end
                reads++;
            end
            if (prev_stall) begin
                n_tests++;
                if (uop_valid !== 1'b1 || uop_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got v=%b data=%h want v=1 data=%h", name, uop_valid, uop_data, prev_data);
                end
            end
            if (uop_valid === 1'b1 && first_v < 0) first_v = k;
            if (uop_valid === 1'b1 && uop_ready) begin
                n_tests++;
                if (got >= n) begin
                    n_fail++;
                    $display("FAIL %s extra_uop: got %h want none", name, uop_data);
                end else if (uop_data !== exp_d[got] || uop_last !== exp_l[got]) begin
                    n_fail++;
                    $display("FAIL %s uop[%0d]: got %h last=%b want %h last=%b",
                             name, got, uop_data, uop_last, exp_d[got], exp_l[got]);
                end
                if (first_hs < 0) first_hs = k;
                last_hs = k;
                got++;
            end
            if (uop_valid === 1'b1 && !uop_ready) stalls++;
            prev_stall = (uop_valid === 1'b1) && !uop_ready;
            prev_data  = uop_data;
            if (done === 1'b1) begin
                done_cnt++;
                n_tests++;
                if (k != last_hs + 1 || got != n) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got cycle %0d after %0d uops want cycle %0d after %0d uops",
                             name, k, got, last_hs + 1, n);
                end
                if (done_k < 0) done_k = k;
            end
        end
        uop_ready = 1'b0;
        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d uops done=%0d after %0d cycles want %0d uops and done", name, got, done_cnt, k, n);
        end
        n_tests++;
        if (got != n || reads != n || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s totals: got uops=%0d reads=%0d dones=%0d want %0d %0d 1", name, got, reads, done_cnt, n, n);
        end
        n_tests++;
        if (first_v != 3) begin
            n_fail++;
            $display("FAIL %s latency: got first valid at cycle %0d want 3", name, first_v);
        end
        if (mode == 0) begin
            n_tests++;
            if (last_hs - first_hs != n - 1) begin
                n_fail++;
                $display("FAIL %s throughput: got %0d cycles for %0d uops want %0d", name, last_hs - first_hs + 1, n, n);
            end
        end
`ifdef UOP_ISSUE_STALL_CNT_EN
        n_tests++;
        if (stall_count !== 16'(stalls)) begin
            n_fail++;
            $display("FAIL %s stall_count: got %0d want %0d", name, stall_count, stalls);
        end
`endif
    endtask

    task automatic test_abort();
        int hs = 0;
        bit ab = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 6'd0; end_addr = 6'd15; loop_count = 8'd0; uop_ready = 1'b1; abort = 1'b0;
        for (int k = 0; k < 40 && !ab; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (uop_valid === 1'b1 && uop_ready) begin
                hs++;
                if (hs == 3) begin
                    abort = 1'b1;
                    ab = 1'b1;
                    n_tests++;
                    if (uop_data !== 32'hA000_0002) begin
                        n_fail++;
                        $display("FAIL abort_third_uop: got %h want a0000002", uop_data);
                    end
                end
            end
        end
        n_tests++;
        if (!ab) begin
            n_fail++;
            $display("FAIL abort_timeout: got %0d handshakes want 3", hs);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        n_tests++;
        if (uop_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cache_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: got v=%b busy=%b done=%b re=%b want 0 0 0 0", uop_valid, busy, done, cache_read_enable);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (uop_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: got v=%b done=%b want 0 0", i, uop_valid, done);
            end
        end
        run_seq(6'd8, 6'd8, 0, 0, 1'b0, "abort_restart");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; start_addr = 6'd0; end_addr = 6'd40; loop_count = 8'd0; uop_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1 || uop_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_running: got busy=%b v=%b want 1 1", busy, uop_valid);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_async");
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset_mid_held");
        @(negedge clk);
        reset = 1'b1;
        uop_ready = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b1; abort = 1'b1; start_addr = 6'd3; end_addr = 6'd5;
        #1;
        n_tests++;
        if (cache_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_same: got re=%b want 0", cache_read_enable);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (busy !== 1'b0 || cache_read_enable !== 1'b0 || uop_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_abort_idle[%0d]: got busy=%b re=%b v=%b want 0 0 0", i, busy, cache_read_enable, uop_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            run_seq(6'($urandom), 6'($urandom), int'($urandom_range(0, 2)), 2, 1'b1, $sformatf("random%0d", t));
        end
    endtask

    initial begin
        test_reset();
        run_seq(6'd4, 6'd7, 0, 0, 1'b0, "basic");
        run_seq(6'd62, 6'd1, 1, 0, 1'b0, "wrap");
        run_seq(6'd0, 6'd9, 0, 1, 1'b0, "stall");
        run_seq(6'd5, 6'd5, 2, 1, 1'b0, "single_loop");
        run_seq(6'd10, 6'd20, 1, 0, 1'b1, "start_while_busy");
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
